// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
//   Time-multiplexed scan driver feeding a 74HC4511-style BCD-to-7-segment
//   decoder. A packed-BCD value is captured into a shadow register. It is
//   copied to the display register only at frame boundaries, so a frame is
//   never torn. One digit is presented per slot. Each slot opens with a
//   blanking window so that the previous digit cannot ghost.
//
// Parameters
//   DIGITS    : digits scanned (1..8)
//   SCAN_DIV  : clock cycles per digit slot (> BLANK_CYC)
//   BLANK_CYC : blanked cycles at the start of each slot (>= 1)
//
// Ports
//   clk, rst   : clock and synchronous active-high reset
//   enable     : 1 = scan, 0 = idle with the display dark
//   load       : 1-cycle strobe that captures data_in into the shadow register
//   data_in    : packed BCD; nibble k is digit k, and digit 0 is least significant
//   lamp_test  : level request for the decoder lamp test
//   bcd        : decoder IN[3:0]
//   le         : decoder LE, held 0 so the decoder stays transparent
//   bi_n       : decoder BI (0 = blank)
//   lt_n       : decoder LT (0 = lamp test)
//   dig_n      : active-low digit commons
//   frame_done : 1-cycle pulse in the cycle after the last slot of a frame
//
// Interface timing: there is no handshake. Every output is a flop that is
//   valid on every cycle. Each flop is loaded with the decode of the
//   next-state values, so an input sampled on one edge is visible at the
//   outputs right after that edge.
//
// Build option: define BCD_SCAN_LZB_EN to enable leading-zero blanking.

module bcd_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  lamp_test,
  output logic [3:0]            bcd,
  output logic                  le,
  output logic                  bi_n,
  output logic                  lt_n,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_done
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0]     SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]     BLANK_LAST = SW'(BLANK_CYC - 1);
  localparam logic [SW-1:0]     SLOT_ONE   = SW'(1);
  localparam logic [DW-1:0]     DIG_LAST   = DW'(DIGITS - 1);
  localparam logic [DW-1:0]     DIG_ONE    = DW'(1);
  localparam logic [DIGITS-1:0] DIG_BIT0   = DIGITS'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  localparam logic [1:0] S_LAMP  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]       dig_idx_q, dig_idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;

  logic [3:0]          bcd_q, bcd_d;
  logic                bi_n_q, bi_n_d;
  logic                lt_n_q, lt_n_d;
  logic [DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                frame_done_q, frame_done_d;

  // Next-state logic. A low enable overrides the lamp test, and the lamp
  // test overrides scanning.
  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    dig_idx_d    = dig_idx_q;
    shadow_d     = load ? data_in : shadow_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;

    if (!enable) begin
      state_d    = S_IDLE;
      slot_cnt_d = '0;
      dig_idx_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_BLANK;
          slot_cnt_d = '0;
          dig_idx_d  = '0;
          disp_d     = shadow_q;
        end
        S_LAMP: begin
          // The counters stay frozen while the lamp test is held. On release,
          // the current digit restarts from the beginning of its slot.
          if (!lamp_test) begin
            state_d    = S_BLANK;
            slot_cnt_d = '0;
          end
        end
        default: begin
          if (lamp_test) begin
            state_d = S_LAMP;
          end else if (state_q == S_BLANK) begin
            slot_cnt_d = slot_cnt_q + SLOT_ONE;
            if (slot_cnt_q == BLANK_LAST) state_d = S_SHOW;
          end else if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            state_d    = S_BLANK;
            if (dig_idx_q == DIG_LAST) begin
              // Frame boundary. A load in this same cycle bypasses the
              // shadow register, so the new value is not delayed by a frame.
              dig_idx_d    = '0;
              frame_done_d = 1'b1;
              disp_d       = load ? data_in : shadow_q;
            end else begin
              dig_idx_d = dig_idx_q + DIG_ONE;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + SLOT_ONE;
          end
        end
      endcase
    end
  end

`ifdef BCD_SCAN_LZB_EN
  // upper_zero[k] is set when disp nibbles k..DIGITS-1 are all zero. It is
  // taken from disp, so the result holds for the whole frame.
  logic [DIGITS-1:0] upper_zero;
  logic              lzb_blank;
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (disp_d[4*DIGITS-1 -: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (disp_d[4*k +: 4] == 4'h0);
    end
    lzb_blank = (dig_idx_d != '0) && upper_zero[dig_idx_d];
  end
`endif

  // Output decode of the next state. It is registered below, so the pins
  // never glitch.
  always_comb begin
    bcd_d   = disp_d[{dig_idx_d, 2'b00} +: 4];
    bi_n_d  = 1'b0;
    lt_n_d  = 1'b1;
    dig_n_d = '1;
    case (state_d)
      S_IDLE: begin
        bcd_d = 4'h0;
      end
      S_SHOW: begin
`ifdef BCD_SCAN_LZB_EN
        bi_n_d = ~lzb_blank;
`else
        bi_n_d = 1'b1;
`endif
        dig_n_d = ~(DIG_BIT0 << dig_idx_d);
      end
      S_LAMP: begin
        bi_n_d  = 1'b1;
        lt_n_d  = 1'b0;
        dig_n_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      bcd_q        <= 4'h0;
      bi_n_q       <= 1'b0;
      lt_n_q       <= 1'b1;
      dig_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      bcd_q        <= bcd_d;
      bi_n_q       <= bi_n_d;
      lt_n_q       <= lt_n_d;
      dig_n_q      <= dig_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd        = bcd_q;
  assign le         = 1'b0;
  assign bi_n       = bi_n_q;
  assign lt_n       = lt_n_q;
  assign dig_n      = dig_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Testbench for bcd_scan_driver (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
// The reference model tracks the scan as a single position within the frame:
// digit = pos / SCAN_DIV and phase = pos % SCAN_DIV.

module tb_bcd_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic        lamp_test = 1'b0;
  logic [3:0]  bcd;
  logic        le;
  logic        bi_n;
  logic        lt_n;
  logic [3:0]  dig_n;
  logic        frame_done;

  bcd_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in),
    .lamp_test(lamp_test), .bcd(bcd), .le(le), .bi_n(bi_n), .lt_n(lt_n),
    .dig_n(dig_n), .frame_done(frame_done)
  );

  // scoreboard state
  logic [11:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit          m_run = 1'b0;
  bit          m_lamp = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_disp = '0;

  // driver: apply one cycle of inputs, advance the model, and queue the outputs expected after the edge
  task automatic step(input bit r, input bit e, input bit l, input logic [15:0] d, input bit lt);
    logic [15:0] new_shadow;
    bit          fd;
    int          digit, phase;
    logic [3:0]  bcd_e, dig_e;
    logic        bi_e, lt_e;
    @(negedge clk);
    rst = r; enable = e; load = l; data_in = d; lamp_test = lt;
    fd = 1'b0;
    if (r) begin
      m_run = 0; m_lamp = 0; m_pos = 0; m_shadow = '0; m_disp = '0;
    end else begin
      new_shadow = l ? d : m_shadow;
      if (!e) begin
        m_run = 0; m_lamp = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; m_disp = m_shadow;
      end else if (lt) begin
        m_lamp = 1;
      end else if (m_lamp) begin
        m_lamp = 0;
        m_pos = (m_pos / SCAN_DIV) * SCAN_DIV;
      end else begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_pos = 0; fd = 1'b1; m_disp = new_shadow;
        end
      end
      m_shadow = new_shadow;
    end
    digit = m_pos / SCAN_DIV;
    phase = m_pos % SCAN_DIV;
    bcd_e = 4'((m_disp >> (4 * digit)) & 16'h000F);
    lt_e  = 1'b1;
    if (!m_run) begin
      bcd_e = 4'h0; bi_e = 1'b0; dig_e = 4'hF;
    end else if (m_lamp) begin
      bi_e = 1'b1; lt_e = 1'b0; dig_e = 4'h0;
    end else if (phase < BLANK_CYC) begin
      bi_e = 1'b0; dig_e = 4'hF;
    end else begin
      bi_e  = 1'b1;
`ifdef BCD_SCAN_LZB_EN
      if (digit > 0 && (m_disp >> (4 * digit)) == 16'h0) bi_e = 1'b0;
`endif
      dig_e = ~(4'b0001 << digit);
    end
    exp_q.push_back({bcd_e, 1'b0, bi_e, lt_e, dig_e, fd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 16'($urandom), 0);
  endtask

  // scan until the model sits at the given digit/phase, with a bounded cycle budget
  task automatic run_until(input int dig, input int ph);
    int i;
    i = 0;
    while (i < 4 * FRAME && !(m_run && !m_lamp && m_pos == dig * SCAN_DIV + ph)) begin
      step(0, 1, 0, 16'($urandom), 0);
      i++;
    end
    if (i == 4 * FRAME) begin
      n_vec++; n_bad++;
      $display("FAIL run_until timeout: digit %0d phase %0d not reached, model pos=%0d", dig, ph, m_pos);
    end
  endtask

  // monitor: every cycle is an output beat; compare 1 time unit after the edge
  logic [11:0] mon_exp, mon_act;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {bcd, le, bi_n, lt_n, dig_n, frame_done};
        n_vec++;
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL scan_out t=%0t got bcd=%h le=%b bi_n=%b lt_n=%b dig_n=%b fd=%b, expected bcd=%h le=%b bi_n=%b lt_n=%b dig_n=%b fd=%b",
                   $time, mon_act[11:8], mon_act[7], mon_act[6], mon_act[5], mon_act[4:1], mon_act[0],
                   mon_exp[11:8], mon_exp[7], mon_exp[6], mon_exp[5], mon_exp[4:1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with random inputs
    repeat (2) step(1, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    // basic scan of 1234
    step(0, 0, 1, 16'h1234, 0);
    run(2 * FRAME + 4);
    // tear-free load during slot 1
    run_until(1, 3);
    step(0, 1, 1, 16'h5678, 0);
    run(2 * FRAME);
    // lamp test during SHOW of digit 2
    run_until(2, BLANK_CYC + 1);
    repeat (3) step(0, 1, 0, 16'($urandom), 1);
    run(FRAME);
    // enable drop at slot 5 of digit 1, then restart
    run_until(1, 5);
    repeat (3) step(0, 0, 0, 16'($urandom), 0);
    run(FRAME + 4);
    // leading zeros
    step(0, 0, 1, 16'h0070, 0);
    run(FRAME + 4);
    // reset mid-slot
    run_until(2, 4);
    step(1, 1, 0, 16'($urandom), 0);
    step(0, 0, 1, 16'h9A0F, 0);
    run(FRAME + 4);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 9) == 0), 16'($urandom), 1'($urandom_range(0, 29) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
